// File: rtl/version_store_pkg.sv
// Shared defaults and state encoding for the versioned slot buffer and its neighbours.
package version_store_pkg;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_VERSION_WIDTH = 4;
    localparam int DEFAULT_VERSION_NUM   = 4;

    // Fill state; mirrors the valid-slot count (0, partial, all slots live)
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/version_store_slot.sv
// One versioned slot: data word, version tag and a valid flag.
// Clearing only drops the valid flag; data and tag stay visible on the buses.
module version_slot
    import version_store_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int VERSION_WIDTH = DEFAULT_VERSION_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     clear,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic [VERSION_WIDTH-1:0] tag_in,
    output logic [DATA_WIDTH-1:0]    data,
    output logic [VERSION_WIDTH-1:0] tag,
    output logic                     valid
);

    // Slot register: reset zeroes everything, clear drops valid, load captures a new word
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            tag   <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            data  <= data_in;
            tag   <= tag_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/version_store.sv
// Versioned slot buffer: tags each accepted word with a wrapping version number and
// keeps the newest VERSION_NUM words in round-robin slots for the downstream router.
module version_store
    import version_store_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int VERSION_WIDTH = DEFAULT_VERSION_WIDTH,
    parameter int VERSION_NUM   = DEFAULT_VERSION_NUM
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wrEn,
    input  logic [DATA_WIDTH-1:0]              wrData,
    output logic                               wrReady,
    input  logic                               flush,
    output logic [VERSION_WIDTH*VERSION_NUM-1:0] versions,
    output logic [DATA_WIDTH*VERSION_NUM-1:0]  dataInputs,
    output logic [VERSION_NUM-1:0]             validMask,
    output logic [VERSION_WIDTH-1:0]           curVersion,
    output logic [$clog2(VERSION_NUM+1)-1:0]   count
);

    localparam int PTR_W = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;
    localparam int CNT_W = $clog2(VERSION_NUM + 1);

    // More slots than distinct tags would let two live slots share a version
    if (VERSION_NUM > 2 ** VERSION_WIDTH) begin : g_bad_params
        $error("version_store: VERSION_NUM exceeds 2**VERSION_WIDTH");
    end

    logic [PTR_W-1:0] wr_ptr;
    state_t           state;
    logic             accept;

    assign wrReady = !flush;
    assign accept  = wrEn && !flush;

    // Write pointer, version counter, fill count and fill-state tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            curVersion <= '0;
            count      <= '0;
            state      <= ST_EMPTY;
        end else if (flush) begin
            // curVersion deliberately keeps running so stale tags never alias new data
            wr_ptr <= '0;
            count  <= '0;
            state  <= ST_EMPTY;
        end else if (wrEn) begin
            curVersion <= curVersion + VERSION_WIDTH'(1);
            wr_ptr     <= (wr_ptr == PTR_W'(VERSION_NUM - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (count != CNT_W'(VERSION_NUM)) begin
                count <= count + CNT_W'(1);
            end
            case (state)
                ST_EMPTY, ST_FILLING:
                    state <= (count == CNT_W'(VERSION_NUM - 1)) ? ST_FULL : ST_FILLING;
                default:
                    state <= ST_FULL;
            endcase
        end
    end

    for (genvar j = 0; j < VERSION_NUM; j++) begin : g_slot
        logic                     load;
        logic [DATA_WIDTH-1:0]    slot_data;
        logic [VERSION_WIDTH-1:0] slot_tag;

        assign load = accept && (wr_ptr == PTR_W'(j));

        version_slot #(
            .DATA_WIDTH    (DATA_WIDTH),
            .VERSION_WIDTH (VERSION_WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .load    (load),
            .clear   (flush),
            .data_in (wrData),
            .tag_in  (curVersion),
            .data    (slot_data),
            .tag     (slot_tag),
            .valid   (validMask[j])
        );

        assign dataInputs[j*DATA_WIDTH +: DATA_WIDTH]       = slot_data;
        assign versions[j*VERSION_WIDTH +: VERSION_WIDTH]   = slot_tag;
    end

endmodule
